// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared types, size codes and alignment check for the MEM-stage load/store initiator
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // req_op bit that selects zero extension on sub-word loads
    localparam int OP_UNSIGNED = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RMW_WRITE,
        RESP
    } lsu_state_t;

    // True for the illegal size code or an address not aligned to the access size
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op[1:0])
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_lo[0];
            SZ_WORD: is_misaligned = |addr_lo;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_initiator_if.sv
// rtl/mem_lsu_initiator_if.sv - request, response and data-memory bundle of the load/store initiator
interface mem_lsu_initiator_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic              mem_ce;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wrdata;
    logic              mem_memwrite;
    logic              mem_memread;
    logic [DATA_W-1:0] mem_rdata;

    // master: the initiator itself; slave: pipeline plus memory around it
    modport master (
        input  req_valid, req_we, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_ce, mem_addr, mem_wrdata, mem_memwrite, mem_memread
    );

    modport slave (
        output req_valid, req_we, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_ce, mem_addr, mem_wrdata, mem_memwrite, mem_memread
    );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - big-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_lane_align
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] rd_word,
    input  logic [31:0] merge_word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_en;

    always_comb begin
        case (offset)
            2'd0:    byte_lane = rd_word[31:24];
            2'd1:    byte_lane = rd_word[23:16];
            2'd2:    byte_lane = rd_word[15:8];
            default: byte_lane = rd_word[7:0];
        endcase
        half_lane = offset[1] ? rd_word[15:0] : rd_word[31:16];
        sign_en   = ~op[OP_UNSIGNED];

        case (op[1:0])
            SZ_BYTE: load_data = {{24{sign_en & byte_lane[7]}}, byte_lane};
            SZ_HALF: load_data = {{16{sign_en & half_lane[15]}}, half_lane};
            default: load_data = rd_word;
        endcase

        merged = merge_word;
        if (op[1:0] == SZ_BYTE) begin
            case (offset)
                2'd0:    merged[31:24] = wdata[7:0];
                2'd1:    merged[23:16] = wdata[7:0];
                2'd2:    merged[15:8]  = wdata[7:0];
                default: merged[7:0]   = wdata[7:0];
            endcase
        end else if (op[1:0] == SZ_HALF) begin
            if (offset[1]) merged[15:0]  = wdata;
            else           merged[31:16] = wdata;
        end
    end
endmodule

// File: rtl/mem_lsu_initiator.sv
// rtl/mem_lsu_initiator.sv - MEM-stage load/store FSM with sub-word read-modify-write; LSU_PERF_CNT_EN adds perf counters
module mem_lsu_initiator
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic reset,
    mem_lsu_initiator_if.master bus
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0] perf_access,
    output logic [31:0] perf_rmw
`endif
);
    lsu_state_t        state;
    logic              we_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              resp_err_q;
    logic [31:0]       load_data;
    logic [31:0]       merged;
    logic              is_word;

    assign is_word = (op_q[1:0] == SZ_WORD);

    lsu_lane_align u_align (
        .op         (op_q),
        .offset     (addr_q[1:0]),
        .rd_word    (bus.mem_rdata),
        .merge_word (merge_q),
        .wdata      (wdata_q[15:0]),
        .load_data  (load_data),
        .merged     (merged)
    );

    // Strobes are gated with reset so a reset edge can never commit a write
    assign bus.req_ready    = (state == IDLE);
    assign bus.mem_ce       = ~reset & ((state == ACCESS) | (state == RMW_WRITE));
    assign bus.mem_memread  = ~reset & (state == ACCESS) & ~(we_q & is_word);
    assign bus.mem_memwrite = ~reset & (((state == ACCESS) & we_q & is_word) | (state == RMW_WRITE));
    assign bus.mem_addr     = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wrdata   = (state == RMW_WRITE) ? merged : wdata_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_err     = resp_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        op_q    <= bus.req_op;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        if (is_misaligned(bus.req_op, bus.req_addr[1:0])) begin
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_err_q   <= 1'b1;
                            state        <= RESP;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q && !is_word) begin
                        merge_q <= bus.mem_rdata;
                        state   <= RMW_WRITE;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= we_q ? '0 : load_data;
                        resp_err_q   <= 1'b0;
                        state        <= RESP;
                    end
                end
                RMW_WRITE: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                    state        <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_access <= '0;
            perf_rmw    <= '0;
        end else begin
            if (state == IDLE && bus.req_valid && !is_misaligned(bus.req_op, bus.req_addr[1:0]))
                perf_access <= perf_access + 32'd1;
            if (state == ACCESS && we_q && !is_word)
                perf_rmw <= perf_rmw + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_lsu_initiator.sv
// tb/tb_mem_lsu_initiator.sv - table, hand-written and randomized checks of mem_lsu_initiator against a byte-level model
module tb_mem_lsu_initiator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_lsu_initiator_if bus ();

`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_access, perf_rmw;
    mem_lsu_initiator dut (.clk(clk), .reset(reset), .bus(bus),
                           .perf_access(perf_access), .perf_rmw(perf_rmw));
`else
    mem_lsu_initiator dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    // Word memory seen by the DUT; byte-addressed reference copy used for expectations
    logic [31:0] mem [0:63];
    logic [7:0]  ref_mem [0:255];

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
    always @(posedge clk) if (bus.mem_memwrite) mem[bus.mem_addr[7:2]] <= bus.mem_wrdata;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic ref_err(input logic [2:0] op, input logic [7:0] addr);
        return (op[1:0] == 2'b11) || ((int'(addr) % size_bytes(op)) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [7:0] addr);
        int n = size_bytes(op);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[int'(addr) + i]);
        if (!op[2] && n == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (!op[2] && n == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] op, input logic [7:0] addr, input logic [31:0] wdata);
        int n = size_bytes(op);
        for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * (n - 1 - i)));
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] addr);
        int b = int'(addr) & ~3;
        return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
    endfunction

    // Issue one request from a negedge; collects per-cycle strobes (bit c = cycle N+c) until resp_valid
    task automatic issue(input logic we, input logic [2:0] op, input logic [7:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output logic [7:0] rdm, output logic [7:0] wrm, output logic ce_any,
                         output logic [31:0] wrd, output logic addr_bad);
        int w = 0;
        rdata = 0; err = 0; lat = -1; rdm = 0; wrm = 0; ce_any = 0; wrd = 0; addr_bad = 0;
        while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_op = op;
        bus.req_addr = {24'h0, addr}; bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_op = 3'($urandom);
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.mem_ce) begin
                ce_any = 1'b1;
                if (bus.mem_addr !== {24'h0, addr[7:2], 2'b00}) addr_bad = 1'b1;
            end
            if (bus.mem_memread) rdm[c] = 1'b1;
            if (bus.mem_memwrite) begin wrm[c] = 1'b1; wrd = bus.mem_wrdata; end
            if (bus.resp_valid) begin lat = c; rdata = bus.resp_rdata; err = bus.resp_err; break; end
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  op;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_wr;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [31:0] rdata, wrd, exp_rd;
        logic err, ce_any, addr_bad, exp_e;
        logic [7:0] rdm, wrm, exp_rdm, exp_wrm;
        int lat, exp_lat, n, stray;
        logic we;
        logic [2:0] op;
        logic [7:0] addr;
        logic [31:0] wdata;

        vecs[0]  = '{0, 3'b010, 8'h10, 0,          32'h8899AABB, 0, 2, 0};
        vecs[1]  = '{0, 3'b000, 8'h11, 0,          32'hFFFFFF99, 0, 2, 0};
        vecs[2]  = '{0, 3'b100, 8'h11, 0,          32'h00000099, 0, 2, 0};
        vecs[3]  = '{0, 3'b000, 8'h13, 0,          32'hFFFFFFBB, 0, 2, 0};
        vecs[4]  = '{0, 3'b001, 8'h12, 0,          32'hFFFFAABB, 0, 2, 0};
        vecs[5]  = '{0, 3'b101, 8'h10, 0,          32'h00008899, 0, 2, 0};
        vecs[6]  = '{1, 3'b000, 8'h13, 32'h000000CC, 32'h0,      0, 3, 32'h8899AACC};
        vecs[7]  = '{0, 3'b010, 8'h10, 0,          32'h8899AACC, 0, 2, 0};
        vecs[8]  = '{0, 3'b010, 8'h11, 0,          32'h0,        1, 1, 0};
        vecs[9]  = '{1, 3'b001, 8'h13, 32'h0000FFFF, 32'h0,      1, 1, 0};
        vecs[10] = '{0, 3'b010, 8'h10, 0,          32'h8899AACC, 0, 2, 0};

        for (int i = 0; i < 64; i++) mem[i] = 32'h01020304 * 32'(i + 1);
        mem[4] = 32'h8899AABB;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i / 4][31 - 8 * (i % 4) -: 8];

        bus.req_valid = 0; bus.req_we = 0; bus.req_op = 0; bus.req_addr = 0; bus.req_wdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 1);
        check("reset_resp_valid", 32'(bus.resp_valid), 0);
        check("reset_resp_rdata", bus.resp_rdata, 0);
        check("reset_resp_err", 32'(bus.resp_err), 0);
        check("reset_mem_ce", 32'(bus.mem_ce), 0);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, rdata, err, lat, rdm, wrm, ce_any, wrd, addr_bad);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].exp_err) check($sformatf("vec%0d_no_ce", i), 32'(ce_any), 0);
            else check($sformatf("vec%0d_mem_addr", i), 32'(addr_bad), 0);
            if (vecs[i].we && !vecs[i].exp_err) begin
                check($sformatf("vec%0d_wrdata", i), wrd, vecs[i].exp_wr);
                check($sformatf("vec%0d_strobes", i), {rdm, wrm}, {8'b0000_0010, 8'b0000_0100});
            end
            if (!vecs[i].we && !vecs[i].exp_err)
                check($sformatf("vec%0d_strobes", i), {rdm, wrm}, {8'b0000_0010, 8'b0});
            if (vecs[i].we && !vecs[i].exp_err) ref_store(vecs[i].op, vecs[i].addr, vecs[i].wdata);
        end

        // Reset landing in the RMW_WRITE cycle of sh 0x10 must abort with memory untouched
        while (!bus.req_ready) @(negedge clk);
        bus.req_valid = 1; bus.req_we = 1; bus.req_op = 3'b001; bus.req_addr = 32'h10; bus.req_wdata = 32'h1234;
        @(posedge clk); #1 bus.req_valid = 0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("abort_memwrite", 32'(bus.mem_memwrite), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_req_ready", 32'(bus.req_ready), 1);
        stray = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.resp_valid) stray++;
            @(negedge clk);
        end
        check("abort_no_resp", 32'(stray), 0);
        check("abort_mem_word", mem[4], ref_word(8'h10));

        for (int t = 0; t < 200; t++) begin
            we = 1'($urandom); op = 3'($urandom); addr = 8'($urandom); wdata = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                n = size_bytes(op);
                if (op[1:0] != 2'b11) addr = 8'(int'(addr) & ~(n - 1));
            end
            exp_e = ref_err(op, addr);
            exp_rd = (we || exp_e) ? 32'h0 : ref_load(op, addr);
            exp_lat = exp_e ? 1 : ((we && size_bytes(op) < 4) ? 3 : 2);
            exp_rdm = (exp_e || (we && size_bytes(op) == 4)) ? 8'b0 : 8'b0000_0010;
            exp_wrm = (exp_e || !we) ? 8'b0 : ((size_bytes(op) == 4) ? 8'b0000_0010 : 8'b0000_0100);
            issue(we, op, addr, wdata, rdata, err, lat, rdm, wrm, ce_any, wrd, addr_bad);
            if (we && !exp_e) ref_store(op, addr, wdata);
            check($sformatf("rnd%0d_rdata", t), rdata, exp_rd);
            check($sformatf("rnd%0d_err", t), 32'(err), 32'(exp_e));
            check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_strobes", t), {16'h0, rdm, wrm}, {16'h0, exp_rdm, exp_wrm});
            check($sformatf("rnd%0d_ce_addr", t), {30'h0, ce_any, addr_bad}, {30'h0, ~exp_e, 1'b0});
            if (we && !exp_e) check($sformatf("rnd%0d_wrdata", t), wrd, ref_word(addr));
        end

        @(negedge clk);
        for (int i = 0; i < 64; i++)
            check($sformatf("final_mem_%0d", i), mem[i], ref_word(8'(i * 4)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
